// File: rtl/bus_timing_pkg.sv
// Slot timing constants and helpers shared by the PET bus scheduler.
// Optional CPU-freeze feature: BUS_SCHEDULER_CPU_STOP_EN.
package bus_timing_pkg;

    localparam int SLOT_PERIOD = 64;

    localparam logic [5:0] WB_FIRST      = 6'd0;
    localparam logic [5:0] WB_LAST       = 6'd23;
    localparam logic [5:0] GUARD_FIRST   = 6'd24;
    localparam logic [5:0] GUARD_LAST    = 6'd25;

    localparam logic [5:0] ADDR_OE_FIRST = 6'd1;
    localparam logic [5:0] ADDR_OE_LAST  = 6'd22;
    localparam logic [5:0] RD_OE_FIRST   = 6'd4;
    localparam logic [5:0] RD_OE_LAST    = 6'd20;
    localparam logic [5:0] RD_CAPTURE    = 6'd20;
    localparam logic [5:0] WR_DOE_FIRST  = 6'd2;
    localparam logic [5:0] WR_DOE_LAST   = 6'd21;
    localparam logic [5:0] WR_WE_FIRST   = 6'd6;
    localparam logic [5:0] WR_WE_LAST    = 6'd18;
    localparam logic [5:0] ACK_CNT       = 6'd22;
    localparam logic [5:0] STOP_CNT      = 6'd23;

    localparam logic [5:0] CPU_BE_FIRST  = 6'd26;
    localparam logic [5:0] CPU_BE_LAST   = 6'd63;
    localparam logic [5:0] CPU_CLK_FIRST = 6'd40;
    localparam logic [5:0] CPU_CLK_LAST  = 6'd63;
    localparam logic [5:0] CPU_RD_FIRST  = 6'd40;
    localparam logic [5:0] CPU_RD_LAST   = 6'd63;
    localparam logic [5:0] CPU_WR_FIRST  = 6'd44;
    localparam logic [5:0] CPU_WR_LAST   = 6'd60;

    typedef enum logic [1:0] {
        SLOT_WB,
        SLOT_GUARD,
        SLOT_CPU
    } slot_e;

    function automatic logic in_win(input logic [5:0] c,
                                    input logic [5:0] lo,
                                    input logic [5:0] hi);
        return (c >= lo) && (c <= hi);
    endfunction

    function automatic slot_e slot_of(input logic [5:0] c);
        if (in_win(c, WB_FIRST, WB_LAST)) return SLOT_WB;
        if (in_win(c, GUARD_FIRST, GUARD_LAST)) return SLOT_GUARD;
        return SLOT_CPU;
    endfunction

endpackage

// File: rtl/bus_scheduler_slot_timer.sv
// Free-running 64-clock slot counter with slot-type decode.
// Part of bus_scheduler (optional macro BUS_SCHEDULER_CPU_STOP_EN unused here).
module slot_timer
    import bus_timing_pkg::*;
(
    input  logic       clock_i,
    input  logic       reset_i,
    output logic [5:0] cycle_o,
    output slot_e      slot_o
);

    logic [5:0] cycle_q;
    logic [5:0] cycle_d;

    always_comb begin
        cycle_d = cycle_q + 6'd1;
        if (cycle_q == 6'(SLOT_PERIOD - 1)) begin
            cycle_d = '0;
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            cycle_q <= '0;
        end else begin
            cycle_q <= cycle_d;
        end
    end

    assign cycle_o = cycle_q;
    assign slot_o  = slot_of(cycle_q);

endmodule

// File: rtl/bus_scheduler.sv
// Time-slot scheduler sharing the PET bus and RAM between the 6502 and the MCU.
// Optional macro BUS_SCHEDULER_CPU_STOP_EN adds cpu_stop_i to freeze the 6502.
module bus_scheduler
    import bus_timing_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int WB_ADDR_WIDTH  = 20,
    parameter int CPU_ADDR_WIDTH = 16,
    parameter int RAM_ADDR_WIDTH = 17
) (
    input  logic                      clock_i,
    input  logic                      reset_i,
    input  logic [WB_ADDR_WIDTH-1:0]  wb_addr_i,
    input  logic [DATA_WIDTH-1:0]     wb_data_i,
    output logic [DATA_WIDTH-1:0]     wb_data_o,
    input  logic                      wb_we_i,
    input  logic                      wb_cyc_i,
    input  logic                      wb_stb_i,
    output logic                      wb_stall_o,
    output logic                      wb_ack_o,
    output logic                      cpu_be_o,
    output logic                      cpu_clk_o,
    input  logic                      cpu_we_i,
    input  logic                      cpu_ram_sel_i,
`ifdef BUS_SCHEDULER_CPU_STOP_EN
    input  logic                      cpu_stop_i,
`endif
    output logic [RAM_ADDR_WIDTH-1:0] bus_addr_o,
    output logic                      bus_addr_oe_o,
    input  logic [DATA_WIDTH-1:0]     bus_data_i,
    output logic [DATA_WIDTH-1:0]     bus_data_o,
    output logic                      bus_data_oe_o,
    output logic                      ram_oe_o,
    output logic                      ram_we_o
);

    logic [5:0] cycle_q;
    logic [5:0] nxt;
    slot_e      slot;

    slot_timer u_slot_timer (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .cycle_o (cycle_q),
        .slot_o  (slot)
    );

    logic                      pending_q, pending_d;
    logic                      svc_q, svc_d;
    logic                      we_q, we_d;
    logic [WB_ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [DATA_WIDTH-1:0]     data_q, data_d;
    logic [DATA_WIDTH-1:0]     wb_data_q, wb_data_d;
    logic                      ack_q, ack_d;
    logic                      cpu_be_q, cpu_be_d;
    logic                      cpu_clk_q, cpu_clk_d;
    logic                      addr_oe_q, addr_oe_d;
    logic [RAM_ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
    logic                      data_oe_q, data_oe_d;
    logic [DATA_WIDTH-1:0]     bus_data_q, bus_data_d;
    logic                      ram_oe_q, ram_oe_d;
    logic                      ram_we_q, ram_we_d;
    logic                      stop_q, stop_d;

    logic accept, is_ram_d, is_ram_q, wb_ram, cpu_ram, cpu_run;

    assign nxt = (cycle_q == 6'(SLOT_PERIOD - 1)) ? '0 : cycle_q + 6'd1;

    always_comb begin
        accept   = wb_cyc_i & wb_stb_i & ~pending_q;
        addr_d   = accept ? wb_addr_i : addr_q;
        data_d   = accept ? wb_data_i : data_q;
        we_d     = accept ? wb_we_i : we_q;
        is_ram_d = addr_d[WB_ADDR_WIDTH-1:RAM_ADDR_WIDTH] == '0;
        is_ram_q = addr_q[WB_ADDR_WIDTH-1:RAM_ADDR_WIDTH] == '0;

        pending_d = pending_q;
        if (accept) begin
            pending_d = 1'b1;
        end else if (svc_q && cycle_q == ACK_CNT) begin
            pending_d = 1'b0;
        end

        // Service is decided once per period, as the WB slot opens.
        svc_d = svc_q;
        if (cycle_q == WB_FIRST) begin
            svc_d = pending_q | accept;
        end else if (slot != SLOT_WB) begin
            svc_d = 1'b0;
        end

`ifdef BUS_SCHEDULER_CPU_STOP_EN
        stop_d  = (cycle_q == STOP_CNT) ? cpu_stop_i : stop_q;
        cpu_run = ~stop_q;
`else
        stop_d  = 1'b0;
        cpu_run = 1'b1;
`endif

        wb_ram  = svc_d & is_ram_d;
        cpu_ram = cpu_run & cpu_ram_sel_i;

        addr_oe_d  = wb_ram & in_win(nxt, ADDR_OE_FIRST, ADDR_OE_LAST);
        bus_addr_d = '0;
        if (addr_oe_d) begin
            bus_addr_d = {addr_d[RAM_ADDR_WIDTH-1:CPU_ADDR_WIDTH],
                          addr_d[CPU_ADDR_WIDTH-1:0]};
        end
        data_oe_d  = wb_ram & we_d & in_win(nxt, WR_DOE_FIRST, WR_DOE_LAST);
        bus_data_d = data_oe_d ? data_d : '0;

        ram_oe_d = (wb_ram & ~we_d & in_win(nxt, RD_OE_FIRST, RD_OE_LAST))
                 | (cpu_ram & ~cpu_we_i & in_win(nxt, CPU_RD_FIRST, CPU_RD_LAST));
        ram_we_d = (wb_ram & we_d & in_win(nxt, WR_WE_FIRST, WR_WE_LAST))
                 | (cpu_ram & cpu_we_i & in_win(nxt, CPU_WR_FIRST, CPU_WR_LAST));

        cpu_be_d  = cpu_run & in_win(nxt, CPU_BE_FIRST, CPU_BE_LAST);
        cpu_clk_d = cpu_run & in_win(nxt, CPU_CLK_FIRST, CPU_CLK_LAST);

        ack_d = svc_d & (nxt == ACK_CNT) & wb_cyc_i;

        wb_data_d = wb_data_q;
        if (svc_q && !we_q && cycle_q == RD_CAPTURE) begin
            wb_data_d = is_ram_q ? bus_data_i : '1;
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            pending_q  <= 1'b0;
            svc_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            wb_data_q  <= '0;
            ack_q      <= 1'b0;
            cpu_be_q   <= 1'b0;
            cpu_clk_q  <= 1'b0;
            addr_oe_q  <= 1'b0;
            bus_addr_q <= '0;
            data_oe_q  <= 1'b0;
            bus_data_q <= '0;
            ram_oe_q   <= 1'b0;
            ram_we_q   <= 1'b0;
            stop_q     <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            svc_q      <= svc_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            wb_data_q  <= wb_data_d;
            ack_q      <= ack_d;
            cpu_be_q   <= cpu_be_d;
            cpu_clk_q  <= cpu_clk_d;
            addr_oe_q  <= addr_oe_d;
            bus_addr_q <= bus_addr_d;
            data_oe_q  <= data_oe_d;
            bus_data_q <= bus_data_d;
            ram_oe_q   <= ram_oe_d;
            ram_we_q   <= ram_we_d;
            stop_q     <= stop_d;
        end
    end

    assign wb_stall_o    = pending_q | reset_i;
    assign wb_ack_o      = ack_q;
    assign wb_data_o     = wb_data_q;
    assign cpu_be_o      = cpu_be_q;
    assign cpu_clk_o     = cpu_clk_q;
    assign bus_addr_o    = bus_addr_q;
    assign bus_addr_oe_o = addr_oe_q;
    assign bus_data_o    = bus_data_q;
    assign bus_data_oe_o = data_oe_q;
    assign ram_oe_o      = ram_oe_q;
    assign ram_we_o      = ram_we_q;

endmodule

// File: doc/bus_scheduler.md
Name: bus_scheduler

Overview:
- Time-slot scheduler sharing the PET address/data bus and the 128 KB RAM between the 6502 and the MCU.
- MCU requests arrive over Wishbone from the SPI1 bridge.
- Divides each 1 µs CPU cycle (64 clocks at 64 MHz) into a Wishbone slot and a CPU slot.
- Generates cpu_be, the 6502 phi2 clock, RAM strobes and bus output enables for main.

Parameters:
DATA_WIDTH, 8, data bus width
WB_ADDR_WIDTH, 20, Wishbone address width
CPU_ADDR_WIDTH, 16, CPU address width
RAM_ADDR_WIDTH, 17, RAM address width

Ports:
clock_i  in  1  64 MHz clock
reset_i  in  1  asynchronous, active-high reset
wb_addr_i  in  WB_ADDR_WIDTH  Wishbone address
wb_data_i  in  DATA_WIDTH  Wishbone write data
wb_data_o  out  DATA_WIDTH  Wishbone read data
wb_we_i  in  1  Wishbone write enable
wb_cyc_i  in  1  Wishbone cycle
wb_stb_i  in  1  Wishbone strobe
wb_stall_o  out  1  Wishbone stall (pipelined)
wb_ack_o  out  1  Wishbone acknowledge
cpu_be_o  out  1  6502 bus enable
cpu_clk_o  out  1  6502 phi2 clock
cpu_we_i  in  1  CPU write, the inverse of R/W
cpu_ram_sel_i  in  1  CPU address decodes to RAM (external decoder)
bus_addr_o  out  RAM_ADDR_WIDTH  RAM address driven by the FPGA during the WB slot
bus_addr_oe_o  out  1  drive bus_addr_o[15:0] onto the CPU address bus
bus_data_i  in  DATA_WIDTH  data bus input
bus_data_o  out  DATA_WIDTH  data bus output
bus_data_oe_o  out  1  drive the data bus
ram_oe_o  out  1  RAM output enable, active high
ram_we_o  out  1  RAM write enable, active high

Behaviour:
- Slot counter cycle_q (6 bits) counts 0..63, wraps 63->0 every clock; reset value 0.
- Reset values: all outputs 0, except wb_stall_o=1 while reset_i is asserted.
- Reset mid-operation: the pending request is discarded, no ack is issued, all strobes drop at once.
- Request accept: when wb_cyc_i & wb_stb_i & !pending_q, latch addr/data/we and set pending_q. wb_stall_o = pending_q | reset_i.
- Only one request is outstanding at a time.
- WB slot, counts 0..23, serviced only if pending_q was set at count 0; otherwise the slot is idle and all strobes stay 0:
  - count 1..22: bus_addr_oe_o=1, bus_addr_o=latched addr[16:0].
  - Read: ram_oe_o=1 for counts 4..20; wb_data_o captures bus_data_i at count 20.
  - Write: bus_data_oe_o=1 for counts 2..21; ram_we_o=1 for counts 6..18.
  - count 22: wb_ack_o pulses for exactly one clock and pending_q clears; the next request is accepted at count 23 or later.
- Non-RAM address: latched addr[19:17] != 0 produces no RAM strobes and no bus drive. Ack still occurs at count 22, with wb_data_o=8'hFF on reads.
- Abort: if wb_cyc_i is low at count 22, the RAM access still completes but ack is suppressed.
- Latency: a request accepted at count 0 acks at count 22; worst case (accepted at count 1) acks 85 clocks later.
- CPU slot, counts 24..63:
  - counts 24..25: guard band, nothing driven.
  - cpu_be_o=1 for counts 26..63.
  - cpu_clk_o=1 for counts 40..63 and 0 otherwise.
  - When cpu_ram_sel_i=1: with cpu_we_i=0, ram_oe_o=1 for counts 40..63; with cpu_we_i=1, ram_we_o=1 for counts 44..60.
  - bus_addr_oe_o and bus_data_oe_o are never asserted during the CPU slot.
- Invariant: bus_addr_oe_o, bus_data_oe_o and cpu_be_o are never high in the same cycle.
- All outputs are registered, with no combinational path from inputs to strobes.

Optional Feature:
- Macro: BUS_SCHEDULER_CPU_STOP_EN.
- With the macro defined: adds input cpu_stop_i. It is sampled at count 23; if high, that CPU slot is suppressed (cpu_be_o=0, cpu_clk_o=0, no CPU RAM strobes), freezing the 6502. WB slots are unaffected.
- Without the macro: no cpu_stop_i port, and the CPU slot runs every period.

Decomposition:
- Package bus_timing_pkg holds:
  - localparams: SLOT_PERIOD=64, and start/end counts for every strobe window above.
  - typedef slot_e {SLOT_WB, SLOT_GUARD, SLOT_CPU}.
- One sub-module, slot_timer: the counter plus slot_e decode. It exports cycle_q and slot.
- Strobe generation and the Wishbone handshake remain in bus_scheduler.

Test Plan:
- Reset, then run 128 clocks with no requests -> cpu_be_o high for counts 26..63, cpu_clk_o high for counts 40..63, bus_addr_oe_o never high.
- WB write at count 0: addr 0x01234, data 0x5A -> bus_addr_o=0x01234 for counts 1..22, ram_we_o for counts 6..18, ack at count 22.
- WB read of addr 0x00010, model RAM returns 0xA5 -> wb_data_o=0xA5 with ack at count 22; wb_stall_o=1 from accept to ack.
- Read of addr 0x80000 -> ack at count 22 with wb_data_o=0xFF and no ram_oe_o.
- Request at count 1 -> stalled, serviced in the next period, acked 85 clocks after accept. Assert reset_i at count 10 of a write -> strobes 0 immediately, no ack, pending cleared.
- With BUS_SCHEDULER_CPU_STOP_EN and cpu_stop_i=1 -> cpu_be_o and cpu_clk_o stay 0 for the whole period, and a WB read still acks.
